// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Shared ALU datapath widths and the operand-loader state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH           = 6;
  localparam int ALU_SEL_W           = 4;
  localparam int LOADER_CNT_W        = 8;
  localparam int LOADER_TIMEOUT_CYC  = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT_B = 2'b01,
    ISSUE  = 2'b10
  } loader_state_t;

  // The loader takes a new word only while it is assembling an operation.
  function automatic logic loader_accepts(input loader_state_t s);
    return (s == IDLE) || (s == WAIT_B);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_loader_timeout.sv
// ============================================================================
// Module : alu_loader_timeout
// Clearable cycle counter that flags the last permitted WAIT_B cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_loader_timeout #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYC < 1) ? 0 : TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYC-th consecutive counted cycle.
  assign expire = count_en && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_operand_loader.sv
// ============================================================================
// Module : alu_operand_loader
// Serial A / B+opcode collector feeding the ALU under a valid/ready handshake.
// Optional WAIT_B abort enabled by macro ALU_LOADER_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH       = ALU_WIDTH,
  parameter int SEL_W       = ALU_SEL_W,
  parameter int CNT_W       = LOADER_CNT_W,
  parameter int TIMEOUT_CYC = LOADER_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [SEL_W-1:0] op_sel,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [CNT_W-1:0] op_count,
  output logic             err_timeout
);

  loader_state_t    state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [SEL_W-1:0] op_sel_q, op_sel_d;
  logic             op_valid_q, op_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             expire;

`ifdef ALU_LOADER_TIMEOUT_EN
  logic err_timeout_q, err_timeout_d;

  alu_loader_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state_q != WAIT_B) || flush),
    .count_en (state_q == WAIT_B),
    .expire   (expire)
  );

  // A B word on the expiry cycle wins, and flush suppresses the error.
  assign err_timeout_d = (state_q == WAIT_B) && !flush && !in_valid && expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign expire             = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    op_valid_d = op_valid_q;
    op_count_d = op_count_q;

    if (flush) begin
      state_d    = IDLE;
      op_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_a_d  = in_data;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (in_valid) begin
            op_b_d     = in_data;
            op_sel_d   = in_sel;
            op_valid_d = 1'b1;
            state_d    = ISSUE;
          end else if (expire) begin
            state_d = IDLE;
          end
        end
        ISSUE: begin
          if (op_ready) begin
            op_valid_d = 1'b0;
            op_count_d = op_count_q + 1'b1;
            state_d    = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          op_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sel_q   <= '0;
      op_valid_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      op_valid_q <= op_valid_d;
      op_count_q <= op_count_d;
    end
  end

  assign in_ready = loader_accepts(state_q);
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_sel   = op_sel_q;
  assign op_valid = op_valid_q;
  assign op_count = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
// ============================================================================
// Module : tb_alu_operand_loader
// Scoreboard bench for alu_operand_loader (timeout cases need ALU_LOADER_TIMEOUT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_loader;

  localparam int W     = 6;
  localparam int SW    = 4;
  localparam int CW    = 2;
  localparam int TMO   = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, op_valid, op_ready, err_timeout;
  logic [W-1:0]  in_data, op_a, op_b;
  logic [SW-1:0] in_sel, op_sel;
  logic [CW-1:0] op_count;

  alu_operand_loader #(
    .WIDTH (W), .SEL_W (SW), .CNT_W (CW), .TIMEOUT_CYC (TMO)
  ) dut (
    .clk (clk), .reset (reset), .flush (flush),
    .in_data (in_data), .in_sel (in_sel), .in_valid (in_valid), .in_ready (in_ready),
    .op_a (op_a), .op_b (op_b), .op_sel (op_sel), .op_valid (op_valid),
    .op_ready (op_ready), .op_count (op_count), .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] sel;
  } op_t;

  op_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks which half of an operation has arrived.
  bit           m_have_a = 0;
  bit           m_pending = 0;
  logic [W-1:0] m_a = '0;
  int           m_wait = 0;
  bit           m_err_exp = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_have_a = 0; m_pending = 0; m_wait = 0; m_err_exp = 0;
        q.delete();
      end else begin
        bit err_next;
        err_next = 0;
        check("in_ready", in_ready, !m_pending);
        check("op_valid", op_valid, m_pending);
        check("err_timeout", err_timeout, m_err_exp);
        if (flush) begin
          if (m_pending && q.size() > 0) void'(q.pop_back());
          m_have_a = 0; m_pending = 0; m_wait = 0;
        end else if (m_pending) begin
          if (op_ready) m_pending = 0;
        end else if (!m_have_a) begin
          if (in_valid) begin
            m_a = in_data; m_have_a = 1; m_wait = 0;
          end
        end else if (in_valid) begin
          q.push_back('{a: m_a, b: in_data, sel: in_sel});
          m_pending = 1; m_have_a = 0;
        end else begin
`ifdef ALU_LOADER_TIMEOUT_EN
          if (m_wait == TMO - 1) begin
            m_have_a = 0; err_next = 1;
          end else begin
            m_wait++;
          end
`endif
        end
        m_err_exp = err_next;
      end
    end
  end

  // Monitor: compares each issued operation against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        exp_cnt = 0;
        check("reset_count", op_count, 0);
      end else if (op_valid && op_ready && !flush) begin
        if (q.size() == 0) begin
          check("unexpected_issue", 1, 0);
        end else begin
          op_t e;
          e = q.pop_front();
          check("op_a", op_a, e.a);
          check("op_b", op_b, e.b);
          check("op_sel", op_sel, e.sel);
          check("op_count_pre", op_count, exp_cnt);
          exp_cnt = (exp_cnt + 1) % (1 << CW);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [SW-1:0] s);
    in_valid = 1; in_data = a; tick();
    in_data = b; in_sel = s; tick();
    in_valid = 0;
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; op_ready = 0; in_data = '0; in_sel = '0;
    repeat (3) tick();
    check("rst_op_a", op_a, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_err", err_timeout, 0);
    reset = 0;
    tick();

    // basic operation
    op_ready = 1;
    load(6'h05, 6'h03, 4'hA);
    tick(); tick();
    check("basic_count", op_count, 1);

    // backpressure
    op_ready = 0;
    load(6'h2A, 6'h15, 4'h3);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_a", op_a, 6'h2A);
      check("bp_hold_b", op_b, 6'h15);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    op_ready = 1;
    tick();
    check("bp_ready_after", in_ready, 1);
    check("bp_count", op_count, 2);

    // flush in WAIT_B together with a B word
    in_valid = 1; in_data = 6'h11; tick();
    flush = 1; in_data = 6'h22; tick();
    flush = 0; in_valid = 0; tick();
    check("flush_wb_valid", op_valid, 0);
    check("flush_wb_count", op_count, 2);

    // flush in ISSUE coinciding with op_ready
    op_ready = 0;
    load(6'h01, 6'h02, 4'h1);
    flush = 1; op_ready = 1; tick();
    flush = 0; op_ready = 0; tick();
    check("flush_is_count", op_count, 2);

    // asynchronous reset while an op is pending
    load(6'h3F, 6'h3E, 4'hF);
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    check("arst_valid", op_valid, 0);
    check("arst_a", op_a, 0);
    check("arst_b", op_b, 0);
    check("arst_sel", op_sel, 0);
    check("arst_count", op_count, 0);
    tick();
    reset = 0;
    tick();

    // count wrap with CNT_W = 2
    op_ready = 1;
    for (int i = 0; i < 5; i++) begin
      load(W'(i + 1), W'(i + 9), SW'(i));
      tick();
    end
    tick();
    check("wrap_count", op_count, 1);

`ifdef ALU_LOADER_TIMEOUT_EN
    // A only: abort after TMO idle WAIT_B cycles
    in_valid = 1; in_data = 6'h0C; tick();
    in_valid = 0;
    repeat (TMO + 2) tick();
    // B arrives on the expiry cycle
    in_valid = 1; in_data = 6'h0D; tick();
    in_valid = 0;
    repeat (TMO - 1) tick();
    in_valid = 1; in_data = 6'h0E; in_sel = 4'h6; tick();
    in_valid = 0;
    repeat (3) tick();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 3) != 0;
      in_data  = W'($urandom);
      in_sel   = SW'($urandom);
      op_ready = ($urandom % 2) != 0;
      flush    = ($urandom % 16) == 0;
      tick();
    end
    flush = 0; in_valid = 0; op_ready = 1;
    repeat (4) tick();
    check("final_count", op_count, exp_cnt);
    check("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
